// File: rtl/clas_seq_16bit.sv
// clas_seq_16bit
// Sequential 16-bit adder/subtractor that reuses one 4-bit carry-look-ahead
// slice over four clocks (LSB nibble first). The carry between nibbles is
// held in a register, so the slice only ever sees one nibble plus carry-in.
// A start/busy/done handshake accepts a new operation in IDLE or DONE, so a
// controller that keeps start high gets one result every five cycles.

module clas_seq_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sel,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        c_out,
    output logic        overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] LAST_SLICE = 2'd3;

    // Control state
    state_t      state_q;
    state_t      state_d;
    logic [1:0]  idx_q;
    logic [1:0]  idx_d;
    logic        carry_q;
    logic        carry_d;

    // Latched operands and operation select
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        sel_q;

    // Partial-sum accumulator and published results
    logic [15:0] acc_q;
    logic [15:0] acc_d;
    logic [15:0] result_q;
    logic [15:0] result_d;
    logic        c_out_q;
    logic        c_out_d;
    logic        ovf_q;
    logic        ovf_d;

    // Slice signals
    logic [3:0]  a_n;
    logic [3:0]  b_n;
    logic [3:0]  slice_sum;
    logic        slice_c3;
    logic        slice_c4;
    logic [5:0]  slice_out;
    logic        accept;
    logic        last_step;

    // 4-bit carry-look-ahead slice.
    // Returns {c4, c3, sum[3:0]}. c3 is the carry into the slice MSB, which
    // together with c4 gives signed overflow when this is the top nibble.
    // Propagate is a|b: equivalent to a^b for the carry terms, and the sum
    // is formed separately with xor.
    function automatic logic [5:0] cla4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       cin
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        logic [3:0] s;
        g    = x & y;
        p    = x | y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = x ^ y ^ c[3:0];
        return {c[4], c[3], s};
    endfunction

    // Handshake decode: a request is taken whenever the unit is not running
    always_comb begin
        accept    = start && (state_q != S_RUN);
        last_step = (state_q == S_RUN) && (idx_q == LAST_SLICE);
    end

    // Slice operand selection and the single shared CLA slice.
    // Subtract is a + ~b + 1: b is inverted here and the +1 enters as the
    // initial carry loaded on accept.
    always_comb begin
        a_n       = a_q[{idx_q, 2'b00} +: 4];
        b_n       = b_q[{idx_q, 2'b00} +: 4] ^ {4{sel_q}};
        slice_out = cla4(a_n, b_n, carry_q);
        slice_sum = slice_out[3:0];
        slice_c3  = slice_out[4];
        slice_c4  = slice_out[5];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start while running is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (idx_q == LAST_SLICE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = start ? S_RUN : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: busy while slicing, done for the single DONE cycle
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    // Next values for slice index, inter-slice carry, accumulator and results
    always_comb begin
        idx_d    = idx_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        if (accept) begin
            idx_d   = 2'd0;
            carry_d = sel;
        end else if (state_q == S_RUN) begin
            idx_d                      = idx_q + 2'd1;
            carry_d                    = slice_c4;
            acc_d[{idx_q, 2'b00} +: 4] = slice_sum;
            if (last_step) begin
                result_d = acc_d;
                c_out_d  = slice_c4;
                ovf_d    = slice_c3 ^ slice_c4;
            end
        end
    end

    // Control registers: index and inter-slice carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
        end
    end

    // Operand capture; only the latched copies feed the slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= 16'd0;
            b_q   <= 16'd0;
            sel_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sel_q <= sel;
        end
    end

    // Accumulator and published results; results move only entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= 16'd0;
            result_q <= 16'd0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
        end
    end

    // Drive result ports from their registers
    always_comb begin
        result   = result_q;
        c_out    = c_out_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_clas_seq_16bit.sv
// Testbench for clas_seq_16bit: directed corner cases, handshake behaviour,
// mid-operation reset and randomized operations against an arithmetic model.

module tb_clas_seq_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        c_out;
    logic        overflow;

    int total;
    int bad;

    logic [15:0] prev_res;

    clas_seq_16bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sel      (sel),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, returns {overflow, c_out, result}
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
        int ux, uy, sx, sy, ur, sr;
        logic co, ov;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!s) begin
            ur = ux + uy;
            sr = sx + sy;
            co = (ur > 65535);
        end else begin
            ur = ux - uy;
            sr = sx - sy;
            co = (ux >= uy);
        end
        ov = (sr > 32767) || (sr < -32768);
        return {ov, co, ur[15:0]};
    endfunction

    // Issue one operation, watch RUN, check latency and results on done
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic ts,
                          input logic [15:0] er, input logic ec, input logic eo,
                          input bit pulse, input string tag);
        int cnt;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tbv;
        sel   = ts;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        sel   = 1'($urandom);
        cnt   = 0;
        while (!done && cnt < 12) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_hold"}, result, prev_res);
            if (pulse && cnt == 1) begin
                start = 1'b1;
                a     = 16'($urandom);
                b     = 16'($urandom);
                sel   = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_lat"}, cnt, 4);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_nbusy"}, busy, 0);
        chk({tag, "_res"}, result, er);
        chk({tag, "_cout"}, c_out, ec);
        chk({tag, "_ovf"}, overflow, eo);
        prev_res = er;
        @(negedge clk);
        chk({tag, "_done1"}, done, 0);
        chk({tag, "_idle_res"}, result, er);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] r;
        logic        c;
        logic        o;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cnt;
        logic [17:0] m;
        logic [15:0] ra, rb;
        logic rs;
        total    = 0;
        bad      = 0;
        prev_res = 16'd0;
        rst_n    = 1'b0;
        start    = 1'b0;
        sel      = 1'b0;
        a        = 16'd0;
        b        = 16'd0;

        vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", result, 0);
        chk("rst_cout", c_out, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases; the first one also pulses start during RUN
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].c, vecs[i].o,
                   (i == 0), $sformatf("dir%0d", i));
        end

        // Back-to-back: start held through RUN and DONE
        @(negedge clk);
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h2222;
        sel   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a   = 16'h4000;
        b   = 16'h4000;
        sel = 1'b0;
        cnt = 0;
        while (!done && cnt < 12) begin
            @(negedge clk);
            cnt++;
        end
        chk("b2b_lat1", cnt, 4);
        chk("b2b_res1", result, 16'h3333);
        prev_res = 16'h3333;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            start = 1'b0;
            if (!done && cnt < 12) begin
                chk("b2b_hold", result, 16'h3333);
                chk("b2b_busy", busy, 1);
            end
        end while (!done && cnt < 12);
        chk("b2b_lat2", cnt, 5);
        chk("b2b_res2", result, 16'h8000);
        chk("b2b_cout2", c_out, 0);
        chk("b2b_ovf2", overflow, 1);
        chk("b2b_nbusy", busy, 0);
        prev_res = 16'h8000;
        @(negedge clk);
        chk("b2b_done1", done, 0);

        // Reset during RUN (E2): outputs clear at once, no done
        @(negedge clk);
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h1111;
        sel   = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_res", result, 0);
        chk("mrst_cout", c_out, 0);
        chk("mrst_ovf", overflow, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mrst_nodone", done, 0);
        end
        rst_n = 1'b1;
        prev_res = 16'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_nodone", done, 0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, "post_rst");

        // Randomized operations, with edge-biased operands every few ops
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (i % 4 == 0) ra = {ra[15], {15{~ra[15]}}};
            if (i % 5 == 0) rb = (i % 2 == 0) ? 16'hFFFF : 16'h8000;
            m = model(ra, rb, rs);
            run_op(ra, rb, rs, m[15:0], m[16], m[17], bit'($urandom_range(0, 1)),
                   $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global safety net against a stuck bench
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
